// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU fetch stage.
//   state_t     : fetch FSM state encoding
//   OP_BEQ/OP_J : opcode field values ([31:26]) for BEQ and J
//   jump_target : absolute J target from pc+4 and the 26-bit index
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/cpu_fetch_unit_next_pc.sv
// Combinational next-PC selection.
//   pc      in  32  address of the current instruction
//   index   in  26  instr[25:0], J target index
//   se_imm  in  32  sign-extended branch offset (in words)
//   branch  in  1   current instruction is BEQ
//   zero    in  1   ALU Zero
//   jump    in  1   current instruction is J (wins over branch)
//   next_pc out 32  fall-through, branch or jump target; wraps mod 2^32
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] index,
  input  logic [31:0] se_imm,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;

  always_comb begin
    pc4 = pc + 32'd4;
    if (jump)
      next_pc = jump_target(pc4, index);
    else if (branch && zero)
      next_pc = pc4 + (se_imm << 2);
    else
      next_pc = pc4;
  end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction
// over a req/ack handshake, presents it to execution, then advances the PC.
//   clk, reset  clock / async active-high reset
//   imem_req    out  fetch request (registered)
//   imem_addr   out  fetch address, always equal to pc
//   imem_ack    in   imem_rdata valid; only honoured while a request is out
//   imem_rdata  in   fetched word
//   instr       out  latched instruction
//   instr_valid out  high for the whole time instr is being executed
//   exec_done   in   current instruction completes this cycle
//   branch, jump, zero, se_imm  in  next-PC controls from decode/execute
//   pc          out  address of current instruction
//   fetch_fault out  sticky timeout flag; unit halts until reset
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  MAX_WAIT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic [31:0] se_imm,
  output logic [31:0] pc,
  output logic        fetch_fault
);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] next_pc;

  assign imem_addr = pc;

  next_pc_calc u_next_pc (
    .pc      (pc),
    .index   (instr[25:0]),
    .se_imm  (se_imm),
    .branch  (branch),
    .zero    (zero),
    .jump    (jump),
    .next_pc (next_pc)
  );

  // wait_cnt holds the 1-based number of the current request cycle, so a
  // request that sees wait_cnt==MAX_WAIT without ack has waited MAX_WAIT
  // cycles; an ack in that same cycle still wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_fault <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!imem_req) begin
            // first cycle out of reset: raise the request, ignore any ack
            imem_req <= 1'b1;
            wait_cnt <= 8'd1;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            wait_cnt    <= '0;
            state       <= EXEC;
          end else if (wait_cnt == MAX_WAIT) begin
            fetch_fault <= 1'b1;
            imem_req    <= 1'b0;
            wait_cnt    <= '0;
            state       <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        EXEC: begin
          if (exec_done) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            wait_cnt    <= 8'd1;
            state       <= FETCH;
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Scoreboard bench for cpu_fetch_unit: stimulus pushes expected fetch
// addresses, instruction words and instr_valid pulse lengths; a negedge
// monitor pops and compares them as the DUT presents them.
module tb_cpu_fetch_unit;
  import cpu_pkg::*;

  localparam logic [7:0] MW = 8'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] se_imm = '0;
  logic [31:0] pc;
  logic        fetch_fault;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];
  int unsigned len_q[$];

  cpu_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MW)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .se_imm      (se_imm),
    .pc          (pc),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor
  int unsigned run = 0;
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else begin
      if (imem_req && imem_ack) begin
        if (addr_q.size() == 0) chk("addr_q_underflow", 32'd1, 32'd0);
        else chk("imem_addr", imem_addr, addr_q.pop_front());
      end
      if (instr_valid) begin
        if (run == 0) begin
          if (instr_q.size() == 0) chk("instr_q_underflow", 32'd1, 32'd0);
          else chk("instr", instr, instr_q.pop_front());
        end
        run++;
      end else if (run > 0) begin
        if (len_q.size() == 0) chk("len_q_underflow", 32'd1, 32'd0);
        else chk("valid_len", run, len_q.pop_front());
        run = 0;
      end
    end
  end

  // All stimulus is applied 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                       input int unsigned ack_wait);
    int unsigned guard;
    addr_q.push_back(exp_addr);
    instr_q.push_back(word);
    guard = 0;
    while (!imem_req && guard < 50) begin
      step();
      guard++;
    end
    if (!imem_req) chk("req_timeout", 32'd0, 32'd1);
    repeat (ack_wait) step();
    chk("no_fault_before_ack", {31'd0, fetch_fault}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h5A5A_5A5A;
  endtask

  task automatic exec(input logic br, input logic jp, input logic zr,
                      input logic [31:0] imm, input int unsigned delay);
    len_q.push_back(delay + 1);
    branch = br; jump = jp; zero = zr; se_imm = imm;
    repeat (delay) step();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0; se_imm = '0;
    chk("valid_drop", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt;
    #3;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("req_low_at_release", {31'd0, imem_req}, 32'd0);
    step();
    chk("req_rises_after_release", {31'd0, imem_req}, 32'd1);

    // sequential fetch with minimum latency
    fetch(32'h0000_0000, 32'h2001_0001, 0); exec(0, 0, 0, '0, 0);
    fetch(32'h0000_0004, 32'h2002_0002, 0); exec(0, 0, 0, '0, 0);
    // J at 0x08, index 4 -> 0x10
    fetch(32'h0000_0008, {OP_J, 26'h000_0004}, 2); exec(0, 1, 0, '0, 1);
    // BEQ taken backwards: 0x14 - 8; ack in the last allowed cycle
    fetch(32'h0000_0010, {OP_BEQ, 26'h3FF_FFFE}, 3); exec(1, 0, 1, 32'hFFFF_FFFE, 2);
    fetch(32'h0000_000C, 32'h0000_0000, 1); exec(0, 0, 0, '0, 0);
    // BEQ not taken
    fetch(32'h0000_0010, {OP_BEQ, 26'h3FF_FFFE}, 0); exec(1, 0, 0, 32'hFFFF_FFFE, 0);
    // BEQ taken to 0x18 + 0xF000_0028
    fetch(32'h0000_0014, {OP_BEQ, 26'h000_000A}, 0); exec(1, 0, 1, 32'h3C00_000A, 0);
    // J keeps pc4[31:28]
    fetch(32'hF000_0040, {OP_J, 26'h000_0100}, 0); exec(0, 1, 0, '0, 0);
    // J wins over a taken branch (branch target would be 0xF000_0408)
    fetch(32'hF000_0400, {OP_J, 26'h000_0100}, 0); exec(1, 1, 1, 32'h0000_0001, 0);
    // BEQ to 0xF000_0404 + 0x0FFF_FBF8
    fetch(32'hF000_0400, {OP_BEQ, 26'h3FF_FEFE}, 0); exec(1, 0, 1, 32'h03FF_FEFE, 0);
    // fall-through wraps
    fetch(32'hFFFF_FFFC, 32'h1111_1111, 0); exec(0, 0, 0, '0, 0);
    fetch(32'h0000_0000, {OP_J, 26'h000_0003}, 0); exec(0, 1, 0, '0, 0);

    // stray ack in EXEC, then reset mid-EXEC
    fetch(32'h0000_000C, 32'hCAFE_0001, 0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("exec_ack_ignored", instr, 32'hCAFE_0001);
    chk("exec_valid_held", {31'd0, instr_valid}, 32'd1);
    chk("exec_pc_held", pc, 32'h0000_000C);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_instr", instr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step(); step();
    reset = 1'b0;
    step();
    chk("stale_ack_req", {31'd0, imem_req}, 32'd1);
    chk("stale_ack_instr", instr, 32'h0);
    imem_ack = 1'b0;
    fetch(32'h0000_0000, 32'h3333_0003, 0); exec(0, 0, 0, '0, 0);

    // timeout at pc=4
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_fault) break;
      if (imem_req) cnt++;
    end
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    chk("wait_cycles", cnt, {24'd0, MW});
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    step();
    imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
    repeat (3) step();
    imem_ack = 1'b0;
    chk("halt_pc", pc, 32'h0000_0004);
    chk("halt_req_ack", {31'd0, imem_req}, 32'd0);
    chk("halt_fault_sticky", {31'd0, fetch_fault}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_clears_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_after_halt_pc", pc, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("refetch_req", {31'd0, imem_req}, 32'd1);

    step();
    chk("addr_q_empty", addr_q.size(), 32'd0);
    chk("instr_q_empty", instr_q.size(), 32'd0);
    chk("len_q_empty", len_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
